fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_sync_ram.sv | 24 ++
 rtl/fifo_sync.sv | 111 +++++++++++
 tb/tb_fifo_sync.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
package fifo_pkg;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } read_mode_e;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage, one write and one registered read port; 1-cycle read latency.
// No backpressure: the owner gates we/re. Contents are never reset.
module fifo_sync_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO, STD (dout 1 cycle after read) or FWFT (head shown whenever non-empty).
// Backpressure: writes rejected while full, reads while empty, each flagged by a 1-cycle pulse.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int         WIDTH             = 32,
  parameter int         DEPTH             = 64,
  parameter read_mode_e READ_MODE         = FWFT,
  parameter int         PROG_FULL_THRESH  = DEPTH - 4,
  parameter int         PROG_EMPTY_THRESH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              din,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic                          prog_full,
  output logic                          prog_empty,
  output logic [fifo_cnt_w(DEPTH)-1:0]  data_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PF_CNT   = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_CNT   = CW'(PROG_EMPTY_THRESH);
  localparam bit FWFT_MODE = (READ_MODE == FWFT);

  if (WIDTH < 1 || WIDTH > 512) begin : g_bad_width
    $error("fifo_sync: WIDTH must be 1..512");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync: DEPTH must be a power of 2, at least 4");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pf
    $error("fifo_sync: PROG_FULL_THRESH must be 1..DEPTH");
  end
  if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pe
    $error("fifo_sync: PROG_EMPTY_THRESH must be 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt, ram_raddr;
  logic             wr_acc, rd_acc, ram_re, byp_hit, byp_q;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] ram_rdata, byp_dat;

  always_comb begin
    wr_acc     = wr_en && !full;
    rd_acc     = rd_en && !empty;
    rd_ptr_nxt = rd_ptr + AW'(rd_acc);
    cnt_nxt    = data_count + CW'(wr_acc) - CW'(rd_acc);
    // FWFT reads the next head every cycle; a same-edge write to that address
    // would be missed by the RAM read, so that word is forwarded from din.
    byp_hit    = FWFT_MODE && wr_acc && (wr_ptr == rd_ptr_nxt);
    ram_raddr  = FWFT_MODE ? rd_ptr_nxt : rd_ptr;
    ram_re     = FWFT_MODE ? 1'b1 : rd_acc;
  end

  fifo_sync_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc && !rst),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      // Bypass path holding zero is what makes dout read 0 out of reset.
      byp_q      <= 1'b1;
      byp_dat    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      data_count <= cnt_nxt;
      full       <= (cnt_nxt == FULL_CNT);
      empty      <= (cnt_nxt == '0);
      prog_full  <= (cnt_nxt >= PF_CNT);
      prog_empty <= (cnt_nxt <= PE_CNT);
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
      if (rd_acc || (FWFT_MODE && wr_acc)) begin
        byp_q   <= byp_hit;
        byp_dat <= din;
      end
    end
  end

  assign dout = byp_q ? byp_dat : ram_rdata;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench: FWFT and STD instances (WIDTH=32, DEPTH=16, thresholds 12/4).
module tb_fifo_sync;
  import fifo_pkg::*;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int CW = fifo_cnt_w(D);

  logic          clk, rst;
  logic          wr_f, rd_f, wr_s, rd_s;
  logic [W-1:0]  din_f, din_s, dout_f, dout_s;
  logic          full_f, empty_f, pf_f, pe_f, ovf_f, udf_f;
  logic          full_s, empty_s, pf_s, pe_s, ovf_s, udf_s;
  logic [CW-1:0] cnt_f, cnt_s;

  fifo_sync #(.WIDTH(W), .DEPTH(D), .READ_MODE(FWFT),
              .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) dut_f (
    .clk(clk), .rst(rst), .wr_en(wr_f), .din(din_f), .rd_en(rd_f), .dout(dout_f),
    .full(full_f), .empty(empty_f), .prog_full(pf_f), .prog_empty(pe_f),
    .data_count(cnt_f), .overflow(ovf_f), .underflow(udf_f));

  fifo_sync #(.WIDTH(W), .DEPTH(D), .READ_MODE(STD),
              .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) dut_s (
    .clk(clk), .rst(rst), .wr_en(wr_s), .din(din_s), .rd_en(rd_s), .dout(dout_s),
    .full(full_s), .empty(empty_s), .prog_full(pf_s), .prog_empty(pe_s),
    .data_count(cnt_s), .overflow(ovf_s), .underflow(udf_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One FWFT cycle checked against a queue model of the FIFO contents.
  task automatic step_f(input logic w, input logic r, input logic [31:0] d, input string tag);
    logic wok, rok;
    int   n;
    wok = w && (mq.size() < D);
    rok = r && (mq.size() > 0);
    wr_f = w; rd_f = r; din_f = d;
    @(posedge clk); #1;
    if (rok) void'(mq.pop_front());
    if (wok) mq.push_back(d);
    n = mq.size();
    check({tag, "_cnt"},   32'(cnt_f), n);
    check({tag, "_empty"}, 32'(empty_f), 32'(n == 0));
    check({tag, "_full"},  32'(full_f), 32'(n == D));
    check({tag, "_pf"},    32'(pf_f), 32'(n >= 12));
    check({tag, "_pe"},    32'(pe_f), 32'(n <= 4));
    check({tag, "_ovf"},   32'(ovf_f), 32'(w && !wok));
    check({tag, "_udf"},   32'(udf_f), 32'(r && !rok));
    if (n > 0) check({tag, "_dout"}, dout_f, mq[0]);
    wr_f = 1'b0; rd_f = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    int          cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        udf;
    logic        chk_dout;
    logic [31:0] dout;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_f = 0; rd_f = 0; din_f = '0;
    wr_s = 0; rd_s = 0; din_s = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout_f",  dout_f, 32'h0);
    check("rst_empty_f", 32'(empty_f), 1);
    check("rst_full_f",  32'(full_f), 0);
    check("rst_pe_f",    32'(pe_f), 1);
    check("rst_pf_f",    32'(pf_f), 0);
    check("rst_cnt_f",   32'(cnt_f), 0);
    check("rst_ovf_f",   32'(ovf_f), 0);
    check("rst_udf_f",   32'(udf_f), 0);
    check("rst_dout_s",  dout_s, 32'h0);
    check("rst_empty_s", 32'(empty_s), 1);
    check("rst_cnt_s",   32'(cnt_s), 0);
    rst = 1'b0;

    // wr rd din | cnt emp ful ovf udf chk dout
    vt[0] = '{1'b1, 1'b1, 32'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55};
    vt[1] = '{1'b0, 1'b0, 32'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55};
    vt[2] = '{1'b1, 1'b1, 32'h66, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66};
    vt[3] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};
    vt[4] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
    vt[5] = '{1'b0, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};
    vt[6] = '{1'b1, 1'b0, 32'h77, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77};
    vt[7] = '{1'b1, 1'b0, 32'h88, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77};
    vt[8] = '{1'b0, 1'b1, 32'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h88};
    vt[9] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};

    for (int i = 0; i < 10; i++) begin
      wr_f = vt[i].wr; rd_f = vt[i].rd; din_f = vt[i].din;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_cnt", i),   32'(cnt_f),   vt[i].cnt);
      check($sformatf("tbl%0d_empty", i), 32'(empty_f), 32'(vt[i].emp));
      check($sformatf("tbl%0d_full", i),  32'(full_f),  32'(vt[i].ful));
      check($sformatf("tbl%0d_ovf", i),   32'(ovf_f),   32'(vt[i].ovf));
      check($sformatf("tbl%0d_udf", i),   32'(udf_f),   32'(vt[i].udf));
      if (vt[i].chk_dout) check($sformatf("tbl%0d_dout", i), dout_f, vt[i].dout);
    end
    wr_f = 1'b0; rd_f = 1'b0;

    // Fill to full, attempt an overflow, then drain in order.
    for (int i = 0; i < 16; i++) step_f(1'b1, 1'b0, 32'(i), $sformatf("fill%0d", i));
    check("fill_full", 32'(full_f), 1);
    check("fill_cnt",  32'(cnt_f), 16);
    step_f(1'b1, 1'b0, 32'hDEAD, "ovf");
    step_f(1'b0, 1'b0, 32'h0, "ovf_after");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_head", i), dout_f, 32'(i));
      step_f(1'b0, 1'b1, 32'h0, $sformatf("drain%0d", i));
    end
    check("drain_empty", 32'(empty_f), 1);

    // Interleaved traffic crossing the pointer wrap and both thresholds.
    for (int k = 0; k < 40; k++) begin
      logic w, r;
      w = (k < 20) ? 1'b1 : (k % 3 == 0);
      r = (k < 20) ? (k % 3 == 2) : 1'b1;
      step_f(w, r, 32'h100 + 32'(k), $sformatf("wrap%0d", k));
    end

    // Full with simultaneous read and write: read wins, write rejected.
    for (int n = 0; n < 20 && mq.size() < D; n++) step_f(1'b1, 1'b0, 32'h200 + 32'(n), "refill");
    step_f(1'b1, 1'b1, 32'hDEAD, "full_rw");
    for (int n = 0; n < 20 && mq.size() > 0; n++) begin
      check("no_dead", 32'(dout_f == 32'hDEAD), 0);
      step_f(1'b0, 1'b1, 32'h0, "drain2");
    end

    // Reset mid-stream with a concurrent write.
    for (int n = 0; n < 7; n++) step_f(1'b1, 1'b0, 32'h300 + 32'(n), "pre_rst");
    check("pre_rst_cnt", 32'(cnt_f), 7);
    rst = 1'b1; wr_f = 1'b1; din_f = 32'hBEEF;
    @(posedge clk); #1;
    rst = 1'b0; wr_f = 1'b0;
    mq.delete();
    check("mid_rst_cnt",   32'(cnt_f), 0);
    check("mid_rst_empty", 32'(empty_f), 1);
    check("mid_rst_dout",  dout_f, 32'h0);
    check("mid_rst_pe",    32'(pe_f), 1);
    check("mid_rst_pf",    32'(pf_f), 0);
    check("mid_rst_full",  32'(full_f), 0);
    step_f(1'b1, 1'b0, 32'h1234, "post_rst_wr");
    step_f(1'b0, 1'b1, 32'h0, "post_rst_rd");

    // STD mode: registered read latency and hold.
    wr_s = 1'b1; din_s = 32'hA1;
    @(posedge clk); #1;
    din_s = 32'hA2;
    @(posedge clk); #1;
    wr_s = 1'b0;
    check("std_cnt2",     32'(cnt_s), 2);
    check("std_noread",   dout_s, 32'h0);
    check("std_empty0",   32'(empty_s), 0);
    rd_s = 1'b1;
    @(posedge clk); #1;
    rd_s = 1'b0;
    check("std_lat_dout", dout_s, 32'hA1);
    check("std_lat_cnt",  32'(cnt_s), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("std_hold%0d", i), dout_s, 32'hA1);
    end
    rd_s = 1'b1;
    @(posedge clk); #1;
    check("std_rd2_dout",  dout_s, 32'hA2);
    check("std_rd2_empty", 32'(empty_s), 1);
    @(posedge clk); #1;
    rd_s = 1'b0;
    check("std_udf",      32'(udf_s), 1);
    check("std_udf_hold", dout_s, 32'hA2);
    @(posedge clk); #1;
    check("std_udf_end",  32'(udf_s), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
